// File: rtl/mul_rand_feeder_if.sv
// Handshake and data bundle between the randomness feeder and its consumer.
// take/take_ack: take is sampled only while vect_valid is high; an accepted take yields a one-cycle take_ack.
interface mul_rand_feeder_if #(
    parameter int D = 2
);
    localparam int N = 2 * (8 + D);

    logic                 seed_load;
    logic [31:0]          seed_i;
    logic                 take;
    logic                 take_ack;
    logic                 vect_valid;
    logic                 busy;
    logic [0:N-1][7:0]    random_vect;
    logic                 state_dbg;

    modport master (
        output seed_load, seed_i, take,
        input  take_ack, vect_valid, busy, random_vect, state_dbg
    );

    modport slave (
        input  seed_load, seed_i, take,
        output take_ack, vect_valid, busy, random_vect, state_dbg
    );
endinterface

// File: rtl/mul_rand_feeder.sv
// Double-buffered random byte source for the masked GF(2^8) multiplier.
// A 32-bit Galois LFSR fills a shadow buffer one byte per cycle; take swaps it onto the output.
module mul_rand_feeder #(
    parameter int          D    = 2,
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic             clk,
    input  logic             rst,
    mul_rand_feeder_if.slave bus
);
    localparam int          N    = 2 * (8 + D);
    localparam int          IW   = $clog2(N);
    localparam logic [31:0] MASK = 32'h8020_0003;

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       lfsr;
    logic [31:0]       lfsr_next;
    logic [IW-1:0]     idx;
    logic [0:N-1][7:0] shadow;
    logic [0:N-1][7:0] vect;
    logic              ack;
    logic              accept;
    logic              last;

    // Eight right shifts of the Galois LFSR per fill cycle.
    always_comb begin
        lfsr_next = lfsr;
        for (int i = 0; i < 8; i++) begin
            if (lfsr_next[0]) lfsr_next = (lfsr_next >> 1) ^ MASK;
            else              lfsr_next = lfsr_next >> 1;
        end
    end

    assign last   = (idx == IW'(N - 1));
    // seed_load has priority over take.
    assign accept = (state == FULL) && bus.take && !bus.seed_load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FILL;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.seed_load)                  state_next = FILL;
        else if (state == FILL && last)     state_next = FULL;
        else if (state == FULL && bus.take) state_next = FILL;
    end

    always_comb begin
        bus.vect_valid = (state == FULL);
        bus.busy       = (state == FILL);
        bus.state_dbg  = state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr   <= SEED;
            idx    <= '0;
            shadow <= '0;
            vect   <= '0;
            ack    <= 1'b0;
        end else begin
            ack <= accept;
            if (bus.seed_load) begin
                lfsr <= (bus.seed_i == 32'h0) ? SEED : bus.seed_i;
                idx  <= '0;
            end else if (state == FILL) begin
                shadow[idx] <= lfsr_next[7:0];
                lfsr        <= lfsr_next;
                idx         <= last ? '0 : idx + 1'b1;
            end else if (accept) begin
                vect <= shadow;
                idx  <= '0;
            end
        end
    end

    assign bus.random_vect = vect;
    assign bus.take_ack    = ack;
endmodule

// File: tb/tb_mul_rand_feeder.sv
// Directed bench for mul_rand_feeder: fill timing, swap contents, seed reload and async reset.
module tb_mul_rand_feeder;
    localparam int          D    = 2;
    localparam int          N    = 2 * (8 + D);
    localparam int          W    = 8 * N;
    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam logic [31:0] MASK = 32'h8020_0003;

    typedef logic [0:N-1][7:0] vect_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [7:0] exp_q[$];
    logic [31:0] model;
    vect_t ev1, ev2, ev3;

    mul_rand_feeder_if #(.D(D)) bus ();

    mul_rand_feeder #(.D(D), .SEED(SEED)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] lfsr8(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ MASK) : (r >> 1);
        return r;
    endfunction

    task automatic model_fill(inout logic [31:0] s);
        for (int i = 0; i < N; i++) begin
            s = lfsr8(s);
            exp_q.push_back(s[7:0]);
        end
    endtask

    task automatic pop_vect(output vect_t v);
        for (int i = 0; i < N; i++) v[i] = exp_q.pop_front();
    endtask

    // drive one take pulse for a single edge
    task automatic pulse_take();
        bus.take = 1'b1;
        step(1);
        bus.take = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed_i    = 32'h0;
        bus.take      = 1'b0;

        model = SEED;
        model_fill(model);
        pop_vect(ev1);
        model_fill(model);
        pop_vect(ev2);
        model = 32'h1;
        model_fill(model);
        pop_vect(ev3);

        step(3);
        check("rst_vv",   W'(bus.vect_valid), W'(0));
        check("rst_busy", W'(bus.busy),       W'(1));
        check("rst_ack",  W'(bus.take_ack),   W'(0));
        check("rst_rv",   W'(bus.random_vect), W'(0));
        rst_n = 1'b1;

        // take on the 5th edge during fill is ignored
        step(4);
        pulse_take();
        check("fill_take_ack", W'(bus.take_ack),    W'(0));
        check("fill_take_rv",  W'(bus.random_vect), W'(0));
        step(14);
        check("e19_vv",   W'(bus.vect_valid), W'(0));
        check("e19_busy", W'(bus.busy),       W'(1));
        step(1);
        check("e20_vv",   W'(bus.vect_valid), W'(1));
        check("e20_busy", W'(bus.busy),       W'(0));
        check("e20_rv",   W'(bus.random_vect), W'(0));

        // first swap
        pulse_take();
        check("swap1_ack",  W'(bus.take_ack),   W'(1));
        check("swap1_rv",   W'(bus.random_vect), W'(ev1));
        check("swap1_vv",   W'(bus.vect_valid), W'(0));
        check("swap1_busy", W'(bus.busy),       W'(1));
        step(1);
        check("swap1_ack_drop", W'(bus.take_ack), W'(0));
        step(18);
        check("refill19_vv", W'(bus.vect_valid),  W'(0));
        check("refill19_rv", W'(bus.random_vect), W'(ev1));
        step(1);
        check("refill20_vv", W'(bus.vect_valid), W'(1));

        // second swap, then seed_load with zero seed 10 edges into the refill
        pulse_take();
        check("swap2_ack", W'(bus.take_ack),   W'(1));
        check("swap2_rv",  W'(bus.random_vect), W'(ev2));
        step(8);
        bus.seed_load = 1'b1;
        bus.seed_i    = 32'h0;
        step(1);
        bus.seed_load = 1'b0;
        check("reseed_vv", W'(bus.vect_valid),  W'(0));
        check("reseed_rv", W'(bus.random_vect), W'(ev2));
        step(19);
        check("reseed29_vv", W'(bus.vect_valid), W'(0));
        step(1);
        check("reseed30_vv", W'(bus.vect_valid), W'(1));
        pulse_take();
        check("swap3_ack", W'(bus.take_ack),   W'(1));
        check("swap3_rv",  W'(bus.random_vect), W'(ev1));

        // seed_load together with take in FULL: reload wins
        step(20);
        check("full4_vv", W'(bus.vect_valid), W'(1));
        bus.seed_load = 1'b1;
        bus.seed_i    = 32'h1;
        bus.take      = 1'b1;
        step(1);
        bus.seed_load = 1'b0;
        bus.take      = 1'b0;
        check("collide_ack",  W'(bus.take_ack),   W'(0));
        check("collide_rv",   W'(bus.random_vect), W'(ev1));
        check("collide_vv",   W'(bus.vect_valid), W'(0));
        check("collide_busy", W'(bus.busy),       W'(1));
        step(19);
        check("seed1_19_vv", W'(bus.vect_valid), W'(0));
        step(1);
        check("seed1_20_vv", W'(bus.vect_valid), W'(1));
        pulse_take();
        check("swap4_ack", W'(bus.take_ack),   W'(1));
        check("swap4_rv",  W'(bus.random_vect), W'(ev3));

        // asynchronous reset between edges while take_ack is high
        #1 rst_n = 1'b0;
        #1;
        check("arst_ack",  W'(bus.take_ack),   W'(0));
        check("arst_vv",   W'(bus.vect_valid), W'(0));
        check("arst_busy", W'(bus.busy),       W'(1));
        check("arst_rv",   W'(bus.random_vect), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step(19);
        check("arst19_vv", W'(bus.vect_valid), W'(0));
        step(1);
        check("arst20_vv", W'(bus.vect_valid), W'(1));
        pulse_take();
        check("swap5_ack", W'(bus.take_ack),   W'(1));
        check("swap5_rv",  W'(bus.random_vect), W'(ev1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
